// File: rtl/pong_match_ctrl.sv
// Match controller for a two-player pong game: score keeping, serve delay,
// pause handling and end-of-match hold, all outputs registered.
module pong_match_ctrl #(
   parameter int SCORE_W     = 4,
   parameter int WIN_SCORE   = 7,
   parameter int SERVE_TICKS = 200,
   parameter int OVER_TICKS  = 300
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               start,
   input  logic               pause,
   input  logic               miss1,
   input  logic               miss2,
   input  logic               time_up,
   output logic [2:0]         state,
   output logic               stop,
   output logic               timer_run,
   output logic               ball_reset,
   output logic               serve_dir,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic [1:0]         winner
);

   localparam int CNT_MAX = (SERVE_TICKS > OVER_TICKS) ? SERVE_TICKS : OVER_TICKS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
   localparam logic [CNT_W-1:0]   SERVE_LD  = CNT_W'(SERVE_TICKS);
   localparam logic [CNT_W-1:0]   OVER_LD   = CNT_W'(OVER_TICKS);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PLAY   = 3'd1,
      SERVE  = 3'd2,
      PAUSED = 3'd3,
      OVER   = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
   logic [1:0]         winner_q, winner_d;
   logic               dir_q, dir_d;
   logic               ball_q, ball_d;
   logic               stop_q, stop_d;
   logic               run_q, run_d;
   logic [SCORE_W-1:0] inc1, inc2;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return (s == SCORE_MAX) ? s : s + 1'b1;
   endfunction

   function automatic logic [1:0] resolve(input logic [SCORE_W-1:0] a,
                                          input logic [SCORE_W-1:0] b);
      if (a > b)      return 2'd1;
      else if (b > a) return 2'd2;
      else            return 2'd3;
   endfunction

   assign inc1 = sat_inc(score1_q);
   assign inc2 = sat_inc(score2_q);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      score1_d = score1_q;
      score2_d = score2_q;
      winner_d = winner_q;
      dir_d    = dir_q;
      ball_d   = 1'b0;

      if ((state_q == SERVE || state_q == OVER) && tick && cnt_q != '0)
         cnt_d = cnt_q - 1'b1;

      case (state_q)
         IDLE: begin
            score1_d = '0;
            score2_d = '0;
            winner_d = 2'd0;
            dir_d    = 1'b0;
            if (start) begin
               state_d = PLAY;
               ball_d  = 1'b1;
            end
         end
         PLAY: begin
            if (time_up) begin
               state_d  = OVER;
               winner_d = resolve(score1_q, score2_q);
               cnt_d    = OVER_LD;
            end else if (miss1 && miss2) begin
               state_d = SERVE;
               ball_d  = 1'b1;
               cnt_d   = SERVE_LD;
            end else if (miss1) begin
               score2_d = inc2;
               if (inc2 == WIN) begin
                  state_d  = OVER;
                  winner_d = 2'd2;
                  cnt_d    = OVER_LD;
               end else begin
                  state_d = SERVE;
                  dir_d   = 1'b0;
                  ball_d  = 1'b1;
                  cnt_d   = SERVE_LD;
               end
            end else if (miss2) begin
               score1_d = inc1;
               if (inc1 == WIN) begin
                  state_d  = OVER;
                  winner_d = 2'd1;
                  cnt_d    = OVER_LD;
               end else begin
                  state_d = SERVE;
                  dir_d   = 1'b1;
                  ball_d  = 1'b1;
                  cnt_d   = SERVE_LD;
               end
            end else if (pause) begin
               state_d = PAUSED;
            end
         end
         SERVE: begin
            if (time_up) begin
               state_d  = OVER;
               winner_d = resolve(score1_q, score2_q);
               cnt_d    = OVER_LD;
            end else if (cnt_q == '0 && start) begin
               state_d = PLAY;
            end
         end
         PAUSED: begin
            if (time_up) begin
               state_d  = OVER;
               winner_d = resolve(score1_q, score2_q);
               cnt_d    = OVER_LD;
            end else if (pause) begin
               state_d = PLAY;
            end
         end
         OVER: begin
            if (cnt_q == '0) begin
               state_d  = IDLE;
               score1_d = '0;
               score2_d = '0;
               winner_d = 2'd0;
               dir_d    = 1'b0;
            end
         end
         default: begin
            state_d  = IDLE;
            cnt_d    = '0;
            score1_d = '0;
            score2_d = '0;
            winner_d = 2'd0;
            dir_d    = 1'b0;
         end
      endcase

      // Motion/timer enables are registered from the next state so they track it exactly.
      stop_d = (state_d != PLAY);
      run_d  = (state_d == PLAY) || (state_d == SERVE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         score1_q <= '0;
         score2_q <= '0;
         winner_q <= 2'd0;
         dir_q    <= 1'b0;
         ball_q   <= 1'b0;
         stop_q   <= 1'b1;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         score1_q <= score1_d;
         score2_q <= score2_d;
         winner_q <= winner_d;
         dir_q    <= dir_d;
         ball_q   <= ball_d;
         stop_q   <= stop_d;
         run_q    <= run_d;
      end
   end

   assign state      = state_q;
   assign stop       = stop_q;
   assign timer_run  = run_q;
   assign ball_reset = ball_q;
   assign serve_dir  = dir_q;
   assign score1     = score1_q;
   assign score2     = score2_q;
   assign winner     = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: directed scenarios plus random
// stimulus checked against a behavioural match model.
`timescale 1ns/1ps
module tb_pong_match_ctrl;

   localparam int SW  = 4;
   localparam int WIN = 3;
   localparam int ST  = 2;
   localparam int OT  = 3;

   logic clk = 1'b0, rst = 1'b0;
   logic tick = 1'b0, start = 1'b0, pause = 1'b0;
   logic miss1 = 1'b0, miss2 = 1'b0, time_up = 1'b0;
   logic [2:0]    state;
   logic          stop, timer_run, ball_reset, serve_dir;
   logic [SW-1:0] score1, score2;
   logic [1:0]    winner;

   int n_cmp  = 0;
   int n_fail = 0;

   // Model of the match: state number, scores, winner, serve direction,
   // remaining delay ticks and whether a ball recentre was just issued.
   int ms, ms1, ms2, mw, mdir, mcnt;
   bit mball;

   pong_match_ctrl #(.SCORE_W(SW), .WIN_SCORE(WIN), .SERVE_TICKS(ST), .OVER_TICKS(OT)) dut (
      .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
      .miss1(miss1), .miss2(miss2), .time_up(time_up),
      .state(state), .stop(stop), .timer_run(timer_run), .ball_reset(ball_reset),
      .serve_dir(serve_dir), .score1(score1), .score2(score2), .winner(winner)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   function automatic int verdict(input int a, input int b);
      if (a > b) return 1;
      if (b > a) return 2;
      return 3;
   endfunction

   task automatic model_reset();
      ms = 0; ms1 = 0; ms2 = 0; mw = 0; mdir = 0; mcnt = 0; mball = 0;
   endtask

   task automatic model_over(input int w);
      ms = 4; mw = w; mcnt = OT;
   endtask

   task automatic model_serve(input int dir);
      ms = 2; mdir = dir; mcnt = ST; mball = 1;
   endtask

   task automatic model_step(input bit tk, input bit st, input bit pa,
                             input bit m1, input bit m2, input bit tu);
      int left;
      left  = mcnt;
      mball = 0;
      if (tk && mcnt > 0 && (ms == 2 || ms == 4)) mcnt = mcnt - 1;
      case (ms)
         0: if (st) begin ms = 1; mball = 1; end
         1: begin
            if (tu) model_over(verdict(ms1, ms2));
            else if (m1 && m2) model_serve(mdir);
            else if (m1) begin
               ms2 = (ms2 < 15) ? ms2 + 1 : 15;
               if (ms2 == WIN) model_over(2); else model_serve(0);
            end else if (m2) begin
               ms1 = (ms1 < 15) ? ms1 + 1 : 15;
               if (ms1 == WIN) model_over(1); else model_serve(1);
            end else if (pa) ms = 3;
         end
         2: begin
            if (tu) model_over(verdict(ms1, ms2));
            else if (left == 0 && st) ms = 1;
         end
         3: begin
            if (tu) model_over(verdict(ms1, ms2));
            else if (pa) ms = 1;
         end
         4: if (left == 0) begin ms = 0; ms1 = 0; ms2 = 0; mw = 0; mdir = 0; end
         default: ms = 0;
      endcase
   endtask

   function automatic logic [16:0] expected_vec();
      return {3'(ms), (ms != 1), (ms == 1 || ms == 2), mball, 1'(mdir),
              4'(ms1), 4'(ms2), 2'(mw)};
   endfunction

   function automatic logic [16:0] observed_vec();
      return {state, stop, timer_run, ball_reset, serve_dir, score1, score2, winner};
   endfunction

   // One clock: drive inputs, let the edge happen, advance the model, settle.
   task automatic cycle(input bit tk, input bit st, input bit pa,
                        input bit m1, input bit m2, input bit tu);
      tick = tk; start = st; pause = pa; miss1 = m1; miss2 = m2; time_up = tu;
      @(posedge clk);
      model_step(tk, st, pa, m1, m2, tu);
      #1;
   endtask

   task automatic serve_back();
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0);
      start = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({state, stop, timer_run, ball_reset, serve_dir, winner} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}
          || score1 !== 4'd0 || score2 !== 4'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_state: got st=%0d stop=%b run=%b br=%b dir=%b s=%0d-%0d w=%0d, want st=0 stop=1 run=0 br=0 dir=0 s=0-0 w=0",
                  state, stop, timer_run, ball_reset, serve_dir, score1, score2, winner);
      end
      @(negedge clk);
      rst = 1'b1;
      cycle(1, 0, 1, 1, 1, 1);
      cycle(1, 0, 0, 1, 0, 0);
      n_cmp++;
      if (state !== 3'd0 || score1 !== 4'd0 || score2 !== 4'd0) begin
         n_fail++;
         $display("[TB] FAIL idle_hold: got st=%0d s=%0d-%0d, want st=0 s=0-0", state, score1, score2);
      end
   endtask

   task automatic test_start();
      cycle(0, 1, 0, 0, 0, 0);
      n_cmp++;
      if (state !== 3'd1 || ball_reset !== 1'b1 || stop !== 1'b0 || timer_run !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL start_play: got st=%0d br=%b stop=%b run=%b, want st=1 br=1 stop=0 run=1",
                  state, ball_reset, stop, timer_run);
      end
      cycle(0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (state !== 3'd1 || ball_reset !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL start_pulse: got st=%0d br=%b, want st=1 br=0", state, ball_reset);
      end
   endtask

   task automatic test_serve_delay();
      cycle(0, 0, 0, 0, 1, 0);
      n_cmp++;
      if (state !== 3'd2 || score1 !== 4'd1 || serve_dir !== 1'b1 || ball_reset !== 1'b1
          || stop !== 1'b1 || timer_run !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL miss2_serve: got st=%0d s1=%0d dir=%b br=%b stop=%b run=%b, want st=2 s1=1 dir=1 br=1 stop=1 run=1",
                  state, score1, serve_dir, ball_reset, stop, timer_run);
      end
      cycle(0, 1, 1, 1, 0, 0);
      n_cmp++;
      if (state !== 3'd2 || score2 !== 4'd0) begin
         n_fail++;
         $display("[TB] FAIL serve_ignore: got st=%0d s2=%0d, want st=2 s2=0", state, score2);
      end
      cycle(1, 1, 0, 0, 0, 0);
      cycle(1, 1, 0, 0, 0, 0);
      n_cmp++;
      if (state !== 3'd2) begin
         n_fail++;
         $display("[TB] FAIL serve_wait: got st=%0d after 2nd tick edge, want 2", state);
      end
      cycle(0, 1, 0, 0, 0, 0);
      n_cmp++;
      if (state !== 3'd1 || ball_reset !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL serve_resume: got st=%0d br=%b, want st=1 br=0", state, ball_reset);
      end
      start = 1'b0;
   endtask

   task automatic test_double_miss();
      cycle(0, 0, 0, 1, 1, 0);
      n_cmp++;
      if (state !== 3'd2 || score1 !== 4'd1 || score2 !== 4'd0 || serve_dir !== 1'b1 || ball_reset !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL double_miss: got st=%0d s=%0d-%0d dir=%b br=%b, want st=2 s=1-0 dir=1 br=1",
                  state, score1, score2, serve_dir, ball_reset);
      end
      serve_back();
   endtask

   task automatic test_draw();
      cycle(0, 0, 0, 1, 0, 0);
      n_cmp++;
      if (state !== 3'd2 || score2 !== 4'd1 || serve_dir !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL miss1_serve: got st=%0d s2=%0d dir=%b, want st=2 s2=1 dir=0", state, score2, serve_dir);
      end
      serve_back();
      cycle(0, 0, 1, 0, 0, 1);
      n_cmp++;
      if (state !== 3'd4 || winner !== 2'd3 || score1 !== 4'd1 || score2 !== 4'd1 || timer_run !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL draw_over: got st=%0d w=%0d s=%0d-%0d run=%b, want st=4 w=3 s=1-1 run=0",
                  state, winner, score1, score2, timer_run);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1, 1, 0, 0, 0, 0);
         n_cmp++;
         if (state !== 3'd4) begin
            n_fail++;
            $display("[TB] FAIL over_hold: got st=%0d at tick %0d, want 4", state, i + 1);
         end
      end
      cycle(0, 1, 0, 0, 0, 0);
      n_cmp++;
      if (state !== 3'd0 || winner !== 2'd0 || score1 !== 4'd0 || score2 !== 4'd0) begin
         n_fail++;
         $display("[TB] FAIL over_idle: got st=%0d w=%0d s=%0d-%0d, want st=0 w=0 s=0-0", state, winner, score1, score2);
      end
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0);
      start = 1'b0;
   endtask

   task automatic test_win();
      cycle(0, 0, 0, 1, 0, 0);
      serve_back();
      cycle(0, 0, 0, 1, 0, 0);
      serve_back();
      n_cmp++;
      if (state !== 3'd1 || score2 !== 4'd2) begin
         n_fail++;
         $display("[TB] FAIL win_setup: got st=%0d s2=%0d, want st=1 s2=2", state, score2);
      end
      cycle(0, 0, 0, 1, 0, 0);
      n_cmp++;
      if (state !== 3'd4 || score2 !== 4'd3 || winner !== 2'd2 || ball_reset !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL win_over: got st=%0d s2=%0d w=%0d br=%b, want st=4 s2=3 w=2 br=0",
                  state, score2, winner, ball_reset);
      end
      repeat (3) cycle(1, 1, 0, 0, 0, 0);
      n_cmp++;
      if (state !== 3'd4 || score2 !== 4'd3) begin
         n_fail++;
         $display("[TB] FAIL win_start_ignored: got st=%0d s2=%0d, want st=4 s2=3", state, score2);
      end
      cycle(0, 1, 0, 0, 0, 0);
      n_cmp++;
      if (state !== 3'd0 || score1 !== 4'd0 || score2 !== 4'd0 || winner !== 2'd0) begin
         n_fail++;
         $display("[TB] FAIL win_idle: got st=%0d s=%0d-%0d w=%0d, want st=0 s=0-0 w=0", state, score1, score2, winner);
      end
      cycle(0, 1, 0, 0, 0, 0);
      start = 1'b0;
   endtask

   task automatic test_pause();
      cycle(0, 0, 0, 0, 1, 0);
      serve_back();
      cycle(0, 0, 1, 0, 0, 0);
      n_cmp++;
      if (state !== 3'd3 || timer_run !== 1'b0 || stop !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL pause_enter: got st=%0d run=%b stop=%b, want st=3 run=0 stop=1", state, timer_run, stop);
      end
      cycle(1, 1, 0, 1, 0, 0);
      n_cmp++;
      if (state !== 3'd3 || score2 !== 4'd0) begin
         n_fail++;
         $display("[TB] FAIL pause_ignore: got st=%0d s2=%0d, want st=3 s2=0", state, score2);
      end
      cycle(0, 0, 1, 0, 0, 0);
      n_cmp++;
      if (state !== 3'd1 || timer_run !== 1'b1 || stop !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL pause_exit: got st=%0d run=%b stop=%b, want st=1 run=1 stop=0", state, timer_run, stop);
      end
      rst = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if ({state, stop, timer_run, ball_reset, serve_dir, winner} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}
          || score1 !== 4'd0 || score2 !== 4'd0) begin
         n_fail++;
         $display("[TB] FAIL async_reset: got st=%0d stop=%b run=%b br=%b dir=%b s=%0d-%0d w=%0d, want st=0 stop=1 run=0 br=0 dir=0 s=0-0 w=0",
                  state, stop, timer_run, ball_reset, serve_dir, score1, score2, winner);
      end
      @(negedge clk);
      rst = 1'b1;
      cycle(1, 0, 1, 1, 1, 1);
      n_cmp++;
      if (state !== 3'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_idle: got st=%0d, want 0", state);
      end
   endtask

   task automatic test_random();
      logic [16:0] exp_v, obs_v;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            rst = 1'b0;
            model_reset();
            #1;
            exp_v = expected_vec();
            obs_v = observed_vec();
            n_cmp++;
            if (obs_v !== exp_v) begin
               n_fail++;
               $display("[TB] FAIL random_reset: cycle %0d got %05h want %05h", i, obs_v, exp_v);
            end
            @(negedge clk);
            rst = 1'b1;
         end else begin
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
            exp_v = expected_vec();
            obs_v = observed_vec();
            n_cmp++;
            if (obs_v !== exp_v) begin
               n_fail++;
               $display("[TB] FAIL random_step: cycle %0d got {st,stop,run,br,dir,s1,s2,w}=%05h want %05h", i, obs_v, exp_v);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_serve_delay();
      test_double_miss();
      test_draw();
      test_win();
      test_pause();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
